core_msg_receiver: RTL and testbench

Core-side receiving end of the scheduler's broadcast message bus. It decodes the strobed 16-bit message stream (active-core mask, R0-load mask, R0 value, instruction words) for one core and buffers the instructions in a FIFO. It hands instructions to the core execution pipeline and drives the core's ready and reading handshakes back to the scheduler. One instance sits in front of each of the 16 cores.

---
 rtl/core_msg_receiver.sv | 215 +++++++++++++++++++++
 tb/tb_core_msg_receiver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_msg_receiver.sv
`default_nettype none
// ============================================================================
// Module   : core_msg_receiver
// Brief    : Per-core receiver for the scheduler broadcast message bus.
//            Decodes strobed mask / R0 / instruction words for one core,
//            buffers instructions in a first-word fall-through FIFO and
//            drives the ready / ready-to-receive handshakes.
// Options  : MSG_OVF_FLAG_EN - enables the sticky overflow flag on 'ovf'.
// Revision : 1.0 - initial release
// ============================================================================
module core_msg_receiver #(
    parameter int          DEPTH   = 16,
    parameter logic [15:0] HALT_OP = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  core_id,
    input  logic        val_mask_ac,
    input  logic        val_mask_R0,
    input  logic        val_R0,
    input  logic        val_ins,
    input  logic [15:0] instruction,
    output logic        rtr,
    output logic        ready,
    output logic        ex_valid,
    output logic [15:0] ex_instr,
    input  logic        ex_pop,
    input  logic        ex_done,
    output logic        r0_wr,
    output logic [15:0] r0_val,
    output logic        ovf
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_LOAD = 2'd1;
    localparam logic [1:0] c_S_RUN  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_active;
    logic               w_next_active;
    logic               r_r0sel;
    logic [15:0]        r_r0_val;
    logic               r_r0_wr;
    logic               r_ready;
    logic               r_rtr;
    logic [15:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_next_count;

    logic w_ac;
    logic w_mr0;
    logic w_r0;
    logic w_ins;
    logic w_bit;
    logic w_full;
    logic w_is_halt;
    logic w_push;
    logic w_pop;
    logic w_flush;
    logic w_r0_load;
`ifdef MSG_OVF_FLAG_EN
    logic w_drop_ovf;
    logic r_ovf;
`endif

    // Strobe priority: only the highest-priority strobe of a cycle is honoured
    assign w_ac      = val_mask_ac;
    assign w_mr0     = val_mask_R0 & ~val_mask_ac;
    assign w_r0      = val_R0 & ~val_mask_R0 & ~val_mask_ac;
    assign w_ins     = val_ins & ~val_R0 & ~val_mask_R0 & ~val_mask_ac;
    assign w_bit     = instruction[core_id];
    assign w_full    = (r_count == c_DEPTH_CNT);
    assign w_is_halt = (instruction == HALT_OP);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and active-flag decode
    always_comb begin
        w_next_state  = r_state;
        w_next_active = r_active;
        case (r_state)
            c_S_IDLE: begin
                if (w_ac) begin
                    w_next_state  = c_S_LOAD;
                    w_next_active = w_bit;
                end
            end
            c_S_LOAD: begin
                if (w_ac) begin
                    w_next_active = w_bit;
                end else if (w_ins && w_is_halt) begin
                    // Inactive cores end the program on a dropped HALT; a HALT
                    // lost to a full FIFO leaves the core loading.
                    if (!r_active) begin
                        w_next_state = c_S_IDLE;
                    end else if (!w_full) begin
                        w_next_state = c_S_RUN;
                    end
                end
            end
            c_S_RUN: begin
                if (ex_done) begin
                    w_next_state = c_S_IDLE;
                end
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    // FIFO control, R0 load strobe and fall-through head presentation
    always_comb begin
        w_flush   = (r_state == c_S_LOAD) && w_ac;
        w_push    = (r_state == c_S_LOAD) && w_ins && r_active && !w_full;
        w_pop     = ex_pop && (r_count != '0) && !w_flush;
        w_r0_load = (r_state == c_S_LOAD) && w_r0 && r_r0sel;
`ifdef MSG_OVF_FLAG_EN
        w_drop_ovf = ((r_state == c_S_LOAD) && w_ins && r_active && w_full) ||
                     ((r_state == c_S_RUN) && w_ins);
`endif
        if (w_flush) begin
            w_next_count = '0;
        end else begin
            w_next_count = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
        ex_valid = (r_count != '0);
        ex_instr = ex_valid ? r_mem[r_rd_ptr] : 16'h0000;
    end

    // Control registers and handshakes, computed from next-cycle values
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active <= 1'b0;
            r_r0sel  <= 1'b0;
            r_r0_val <= 16'h0000;
            r_r0_wr  <= 1'b0;
            r_ready  <= 1'b1;
            r_rtr    <= 1'b1;
        end else begin
            r_active <= w_next_active;
            if ((r_state == c_S_LOAD) && w_mr0) begin
                r_r0sel <= w_bit;
            end
            if (w_r0_load) begin
                r_r0_val <= instruction;
            end
            r_r0_wr <= w_r0_load;
            r_ready <= (w_next_state == c_S_IDLE) || !w_next_active;
            r_rtr   <= (w_next_state != c_S_RUN) && (w_next_count < c_DEPTH_CNT);
        end
    end

    // FIFO pointers and occupancy; a flush rewinds both pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
            end
            r_count <= w_next_count;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= instruction;
        end
    end

`ifdef MSG_OVF_FLAG_EN
    // Sticky overflow: set on any word lost to a full FIFO or sent during RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop_ovf) begin
            r_ovf <= 1'b1;
        end
    end
    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign rtr    = r_rtr;
    assign ready  = r_ready;
    assign r0_wr  = r_r0_wr;
    assign r0_val = r_r0_val;

endmodule
`default_nettype wire

// File: tb/tb_core_msg_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_msg_receiver
// Brief    : Self-checking bench for core_msg_receiver: directed vector table,
//            hand-written corner sequences and random traffic compared with a
//            queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_msg_receiver;

    localparam int DEPTH = 16;
`ifdef MSG_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    localparam logic [3:0] AC  = 4'b1000;
    localparam logic [3:0] MR0 = 4'b0100;
    localparam logic [3:0] R0  = 4'b0010;
    localparam logic [3:0] INS = 4'b0001;
    localparam logic [3:0] NOP = 4'b0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  core_id;
    logic        val_mask_ac, val_mask_R0, val_R0, val_ins;
    logic [15:0] instruction;
    logic        rtr, ready, ex_valid;
    logic [15:0] ex_instr;
    logic        ex_pop, ex_done;
    logic        r0_wr;
    logic [15:0] r0_val;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_msg_receiver #(.DEPTH(DEPTH), .HALT_OP(16'hFFFF)) dut (
        .clk(clk), .reset(reset), .core_id(core_id),
        .val_mask_ac(val_mask_ac), .val_mask_R0(val_mask_R0),
        .val_R0(val_R0), .val_ins(val_ins), .instruction(instruction),
        .rtr(rtr), .ready(ready), .ex_valid(ex_valid), .ex_instr(ex_instr),
        .ex_pop(ex_pop), .ex_done(ex_done), .r0_wr(r0_wr), .r0_val(r0_val),
        .ovf(ovf)
    );

    // Behavioural reference: program buffer as a queue, mode 0/1/2 = idle/load/run
    logic [15:0] m_q[$];
    int          m_mode;
    bit          m_active, m_r0sel, m_r0_wr, m_ovf;
    logic [15:0] m_r0_val;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int sz = m_q.size();
        bit b = instruction[core_id];
        bit ac = val_mask_ac;
        bit mr0 = val_mask_R0 && !ac;
        bit r0 = val_R0 && !val_mask_R0 && !ac;
        bit ins = val_ins && !val_R0 && !val_mask_R0 && !ac;
        bit do_pop = ex_pop && (sz > 0);
        m_r0_wr = 1'b0;
        if (reset) begin
            m_q.delete();
            m_mode = 0; m_active = 0; m_r0sel = 0; m_r0_val = '0; m_ovf = 0;
            return;
        end
        case (m_mode)
            0: if (ac) begin m_active = b; m_mode = 1; end
            1: begin
                if (ac) begin
                    m_q.delete(); m_active = b; do_pop = 0;
                end else if (mr0) begin
                    m_r0sel = b;
                end else if (r0) begin
                    if (m_r0sel) begin m_r0_val = instruction; m_r0_wr = 1; end
                end else if (ins) begin
                    if (!m_active) begin
                        if (instruction == 16'hFFFF) m_mode = 0;
                    end else if (sz == DEPTH) begin
                        m_ovf = m_ovf | OVF_EN;
                    end else begin
                        m_q.push_back(instruction);
                        if (instruction == 16'hFFFF) m_mode = 2;
                    end
                end
            end
            default: begin
                if (ins) m_ovf = m_ovf | OVF_EN;
                if (ex_done) m_mode = 0;
            end
        endcase
        if (do_pop) void'(m_q.pop_front());
    endtask

    task automatic cmp_model();
        chk("model ex_valid", ex_valid, (m_q.size() > 0));
        chk("model ex_instr", ex_instr, (m_q.size() > 0) ? m_q[0] : 16'h0000);
        chk("model ready", ready, (m_mode == 0) || !m_active);
        chk("model rtr", rtr, (m_mode != 2) && (m_q.size() < DEPTH));
        chk("model r0_wr", r0_wr, m_r0_wr);
        chk("model r0_val", r0_val, m_r0_val);
        chk("model ovf", ovf, m_ovf);
    endtask

    task automatic step(input logic [3:0] str, input logic [15:0] ins,
                        input logic pop, input logic done);
        {val_mask_ac, val_mask_R0, val_R0, val_ins} = str;
        instruction = ins;
        ex_pop = pop;
        ex_done = done;
        model_step();
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic do_reset(input logic [3:0] cid);
        reset = 1'b1;
        core_id = cid;
        step(NOP, 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  cid;
        logic [3:0]  str;
        logic [15:0] ins;
        logic        pop, done;
        logic        ev;
        logic [15:0] ei;
        logic        rdy, rt, r0w;
        logic [15:0] r0v;
    } vec_t;

    localparam int NV = 20;
    vec_t tv [NV];

    initial begin
        // cid, strobes, bus, pop, done | ex_valid, ex_instr, ready, rtr, r0_wr, r0_val
        tv[0]  = '{4'd3, AC,  16'h0008, 0, 0, 0, 16'h0000, 0, 1, 0, 16'h0000};
        tv[1]  = '{4'd3, MR0, 16'h0008, 0, 0, 0, 16'h0000, 0, 1, 0, 16'h0000};
        tv[2]  = '{4'd3, R0,  16'h1234, 0, 0, 0, 16'h0000, 0, 1, 1, 16'h1234};
        tv[3]  = '{4'd3, INS, 16'hA001, 0, 0, 1, 16'hA001, 0, 1, 0, 16'h1234};
        tv[4]  = '{4'd3, INS, 16'hA002, 0, 0, 1, 16'hA001, 0, 1, 0, 16'h1234};
        tv[5]  = '{4'd3, INS, 16'hFFFF, 0, 0, 1, 16'hA001, 0, 0, 0, 16'h1234};
        tv[6]  = '{4'd3, NOP, 16'h0000, 1, 0, 1, 16'hA002, 0, 0, 0, 16'h1234};
        tv[7]  = '{4'd3, NOP, 16'h0000, 1, 0, 1, 16'hFFFF, 0, 0, 0, 16'h1234};
        tv[8]  = '{4'd3, NOP, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0, 16'h1234};
        tv[9]  = '{4'd3, NOP, 16'h0000, 0, 1, 0, 16'h0000, 1, 1, 0, 16'h1234};
        tv[10] = '{4'd5, AC,  16'h0008, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h1234};
        tv[11] = '{4'd5, MR0, 16'h0008, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h1234};
        tv[12] = '{4'd5, R0,  16'h5678, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h1234};
        tv[13] = '{4'd5, INS, 16'hA001, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h1234};
        tv[14] = '{4'd5, INS, 16'hFFFF, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h1234};
        tv[15] = '{4'd5, AC|INS, 16'hFFFF, 0, 0, 0, 16'h0000, 0, 1, 0, 16'h1234};
        tv[16] = '{4'd5, INS, 16'h0010, 0, 0, 1, 16'h0010, 0, 1, 0, 16'h1234};
        tv[17] = '{4'd5, AC,  16'h0000, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h1234};
        tv[18] = '{4'd5, INS, 16'hFFFF, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h1234};
        tv[19] = '{4'd5, INS, 16'hFFFF, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h1234};

        {val_mask_ac, val_mask_R0, val_R0, val_ins} = NOP;
        instruction = '0; ex_pop = 0; ex_done = 0;
        do_reset(4'd3);

        // Reset values
        chk("reset rtr", rtr, 1'b1);
        chk("reset ready", ready, 1'b1);
        chk("reset ex_valid", ex_valid, 1'b0);
        chk("reset ex_instr", ex_instr, 16'h0000);
        chk("reset r0_wr", r0_wr, 1'b0);
        chk("reset r0_val", r0_val, 16'h0000);
        chk("reset ovf", ovf, 1'b0);

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            core_id = tv[i].cid;
            step(tv[i].str, tv[i].ins, tv[i].pop, tv[i].done);
            chk($sformatf("tv%0d ex_valid", i), ex_valid, tv[i].ev);
            chk($sformatf("tv%0d ex_instr", i), ex_instr, tv[i].ei);
            chk($sformatf("tv%0d ready", i), ready, tv[i].rdy);
            chk($sformatf("tv%0d rtr", i), rtr, tv[i].rt);
            chk($sformatf("tv%0d r0_wr", i), r0_wr, tv[i].r0w);
            chk($sformatf("tv%0d r0_val", i), r0_val, tv[i].r0v);
        end

        // Fill to capacity, overflow with a 17th word, then drain in order
        do_reset(4'd0);
        step(AC, 16'hFFFF, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(INS, 16'(i), 0, 0);
            chk($sformatf("fill rtr after push %0d", i + 1), rtr, (i != DEPTH - 1));
        end
        step(INS, 16'h0010, 0, 0);
        chk("overflow ovf", ovf, OVF_EN);
        chk("overflow head", ex_instr, 16'h0000);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain head %0d", i), ex_instr, 16'(i));
            step(NOP, 16'h0000, 1, 0);
        end
        chk("drain empty", ex_valid, 1'b0);
        chk("drain rtr", rtr, 1'b1);

        // Re-arriving mask with 5 words buffered flushes and deactivates
        do_reset(4'd0);
        step(AC, 16'hFFFF, 0, 0);
        for (int i = 0; i < 5; i++) step(INS, 16'hB000 + 16'(i), 0, 0);
        chk("flush pre ex_valid", ex_valid, 1'b1);
        chk("flush pre ready", ready, 1'b0);
        step(AC, 16'h0000, 0, 0);
        chk("flush ex_valid", ex_valid, 1'b0);
        chk("flush ready", ready, 1'b1);

        // Reset mid-load with an R0 write in flight
        do_reset(4'd0);
        step(AC, 16'hFFFF, 0, 0);
        step(MR0, 16'hFFFF, 0, 0);
        for (int i = 0; i < 4; i++) step(INS, 16'hC000 + 16'(i), 0, 0);
        reset = 1'b1;
        step(R0, 16'hBEEF, 0, 0);
        reset = 1'b0;
        chk("midreset r0_wr", r0_wr, 1'b0);
        chk("midreset r0_val", r0_val, 16'h0000);
        chk("midreset ex_valid", ex_valid, 1'b0);
        chk("midreset ex_instr", ex_instr, 16'h0000);
        chk("midreset ready", ready, 1'b1);
        chk("midreset rtr", rtr, 1'b1);
        step(NOP, 16'h0000, 0, 0);
        chk("midreset r0_wr later", r0_wr, 1'b0);

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  str;
            logic [15:0] w;
            int          r;
            if (n % 500 == 0) do_reset(4'($urandom_range(0, 15)));
            r = $urandom_range(0, 99);
            if (r < 4)       str = AC;
            else if (r < 8)  str = MR0;
            else if (r < 14) str = R0;
            else if (r < 60) str = INS;
            else if (r < 64) str = 4'($urandom_range(0, 15));
            else             str = NOP;
            w = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            step(str, w, ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0));
            reset = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
